mips_state_sequencer: RTL



---
 rtl/mips_pkg.sv | 34 +++
 rtl/mips_perf_counter.sv | 28 ++
 rtl/mips_state_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: the sequencer state
// encoding used by mips_state_sequencer and the control_signal decoder,
// the supported final_code values and the opcode/func_code decode helper.
package mips_pkg;

    typedef enum logic [2:0] {
        STATE_FETCH         = 3'b000,
        STATE_DECODE        = 3'b001,
        STATE_EXECUTE       = 3'b010,
        STATE_MEMORY_ACCESS = 3'b011,
        STATE_WRITE_BACK    = 3'b100,
        STATE_HALT          = 3'b101,
        STATE_RESET         = 3'b111
    } state_t;

    localparam logic [5:0] FC_ADDU  = 6'b100001;
    localparam logic [5:0] FC_JR    = 6'b001000;
    localparam logic [5:0] FC_ADDIU = 6'b001001;
    localparam logic [5:0] FC_LW    = 6'b100011;
    localparam logic [5:0] FC_SW    = 6'b101011;

    // R-type instructions are identified by their function field.
    function automatic logic [5:0] decode_final_code(input logic [5:0] opcode,
                                                     input logic [5:0] func_code);
        logic [5:0] code;
        if (opcode == 6'd0) begin
            code = func_code;
        end else begin
            code = opcode;
        end
        return code;
    endfunction

endpackage

// File: rtl/mips_perf_counter.sv
// 32-bit saturating event counter with increment enable.
// Only built when MIPS_STATE_SEQ_PERF_COUNTERS_EN is defined, which is the
// only configuration that instantiates it.
`ifdef MIPS_STATE_SEQ_PERF_COUNTERS_EN
module mips_perf_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_r;

    // Count enabled events, sticking at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 32'h0000_0000;
        end else if (inc && (count_r != 32'hFFFF_FFFF)) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule
`endif

// File: rtl/mips_state_sequencer.sv
// Multi-cycle state sequencer for the MIPS core. Steps each instruction
// through FETCH/DECODE/EXECUTE/MEMORY_ACCESS/WRITE_BACK, skipping stages by
// final_code, stalls on waitrequest in FETCH and MEMORY_ACCESS, and parks in
// HALT on a JR to address 0 or an unsupported instruction.
// Optional feature macro: MIPS_STATE_SEQ_PERF_COUNTERS_EN (cycle and
// retired-instruction counters; ports read 32'h0 when undefined).
module mips_state_sequencer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func_code,
    input  logic        waitrequest,
    input  logic        rs_zero,
    output logic [2:0]  state,
    output logic        active,
    output logic        illegal,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    state_t     state_r;
    state_t     state_next_s;
    logic       active_r;
    logic       active_next_s;
    logic       illegal_r;
    logic       illegal_next_s;
    logic [5:0] final_code_s;

    // opcode/func_code are only meaningful from EXECUTE onward; earlier
    // states never look at final_code_s.
    assign final_code_s = decode_final_code(opcode, func_code);

    // State, run flag and sticky illegal flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= STATE_RESET;
            active_r  <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            active_r  <= active_next_s;
            illegal_r <= illegal_next_s;
        end
    end

    // Next-state selection plus active/illegal updates on the entering edge
    always_comb begin
        state_next_s   = state_r;
        active_next_s  = active_r;
        illegal_next_s = illegal_r;
        case (state_r)
            STATE_RESET: begin
                state_next_s  = STATE_FETCH;
                active_next_s = 1'b1;
            end
            STATE_FETCH: begin
                if (waitrequest) begin
                    state_next_s = STATE_FETCH;
                end else begin
                    state_next_s = STATE_DECODE;
                end
            end
            STATE_DECODE: begin
                state_next_s = STATE_EXECUTE;
            end
            STATE_EXECUTE: begin
                case (final_code_s)
                    FC_LW, FC_SW: begin
                        state_next_s = STATE_MEMORY_ACCESS;
                    end
                    FC_ADDU, FC_ADDIU: begin
                        state_next_s = STATE_WRITE_BACK;
                    end
                    FC_JR: begin
                        if (rs_zero) begin
                            state_next_s  = STATE_HALT;
                            active_next_s = 1'b0;
                        end else begin
                            state_next_s = STATE_FETCH;
                        end
                    end
                    default: begin
                        state_next_s   = STATE_HALT;
                        active_next_s  = 1'b0;
                        illegal_next_s = 1'b1;
                    end
                endcase
            end
            STATE_MEMORY_ACCESS: begin
                if (waitrequest) begin
                    state_next_s = STATE_MEMORY_ACCESS;
                end else if (final_code_s == FC_LW) begin
                    state_next_s = STATE_WRITE_BACK;
                end else begin
                    state_next_s = STATE_FETCH;
                end
            end
            STATE_WRITE_BACK: begin
                state_next_s = STATE_FETCH;
            end
            STATE_HALT: begin
                state_next_s = STATE_HALT;
            end
            default: begin
                // Unreachable encoding: stop the CPU rather than guess.
                state_next_s  = STATE_HALT;
                active_next_s = 1'b0;
            end
        endcase
    end

    assign state   = state_r;
    assign active  = active_r;
    assign illegal = illegal_r;

`ifdef MIPS_STATE_SEQ_PERF_COUNTERS_EN
    logic retire_s;

    // An instruction retires when it returns to FETCH, or on a halting JR;
    // an illegal instruction halts without retiring.
    always_comb begin
        retire_s = 1'b0;
        case (state_r)
            STATE_EXECUTE: begin
                if (final_code_s == FC_JR) begin
                    retire_s = 1'b1;
                end else begin
                    retire_s = 1'b0;
                end
            end
            STATE_MEMORY_ACCESS, STATE_WRITE_BACK: begin
                if (state_next_s == STATE_FETCH) begin
                    retire_s = 1'b1;
                end else begin
                    retire_s = 1'b0;
                end
            end
            default: begin
                retire_s = 1'b0;
            end
        endcase
    end

    mips_perf_counter u_cycle_counter (
        .clk   (clk),
        .rst_n (reset_n),
        .inc   (active_r),
        .count (cycle_count)
    );

    mips_perf_counter u_instr_counter (
        .clk   (clk),
        .rst_n (reset_n),
        .inc   (retire_s),
        .count (instr_count)
    );
`else
    assign cycle_count = 32'h0000_0000;
    assign instr_count = 32'h0000_0000;
`endif

endmodule
